// File: rtl/down_timer_if.sv
// Control and status bundle for down_timer.
// The master drives the control inputs and the slave (the timer) drives the count and status.
interface down_timer_if #(
  parameter int unsigned W = 4
) ();
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         mode;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  logic         done;

  modport master (
    output load, load_val, start, pause, mode,
    input  q, tc, busy, done
  );

  modport slave (
    input  load, load_val, start, pause, mode,
    output q, tc, busy, done
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and pause/resume.
// tc pulses for one cycle in the cycle q first reads zero.
module down_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  bus
);

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_q;
  logic [W-1:0] w_q_nxt;
  logic [W-1:0] r_reload;
  logic [W-1:0] w_reload_nxt;
  logic         r_tc;
  logic         w_tc_nxt;
  logic         r_busy;
  logic         w_busy_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic         w_can_start;

  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);

  // Next-state and datapath; priority is load > start > pause > state default.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (bus.load) begin
      w_reload_nxt = bus.load_val;
      w_q_nxt      = bus.load_val;
      w_state_nxt  = S_IDLE;
    end else if (bus.start && w_can_start) begin
      if (r_reload != ZERO) begin
        w_q_nxt     = r_reload;
        w_state_nxt = S_RUN;
      end else begin
        // Zero interval: terminal count immediately, no RUN cycle.
        w_q_nxt     = ZERO;
        w_tc_nxt    = 1'b1;
        w_state_nxt = bus.mode ? S_IDLE : S_DONE;
      end
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (bus.pause) begin
            w_state_nxt = S_HOLD;
          end else if (r_q == ZERO) begin
            w_q_nxt = r_reload;
          end else if (r_q == ONE) begin
            w_q_nxt  = ZERO;
            w_tc_nxt = 1'b1;
            if (!bus.mode) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_q_nxt = r_q - ONE;
          end
        end
        S_HOLD: begin
          if (!bus.pause) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          w_q_nxt = ZERO;
        end
        default: begin
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and output registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized traffic
// compared against a behavioural model of the timer.
module tb_down_timer;

  localparam int unsigned W = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst;

  down_timer_if #(.W(W)) bus ();

  down_timer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int unsigned m_q   = 0;
  int unsigned m_rl  = 0;
  int          m_st  = M_IDLE;
  bit          m_tc  = 1'b0;

  task automatic model_step();
    if (rst) begin
      m_q = 0; m_rl = 0; m_st = M_IDLE; m_tc = 1'b0;
    end else if (bus.load) begin
      m_rl = int'(bus.load_val); m_q = m_rl; m_st = M_IDLE; m_tc = 1'b0;
    end else if (bus.start && (m_st == M_IDLE || m_st == M_DONE)) begin
      if (m_rl != 0) begin
        m_q = m_rl; m_st = M_RUN; m_tc = 1'b0;
      end else begin
        m_q = 0; m_tc = 1'b1; m_st = bus.mode ? M_IDLE : M_DONE;
      end
    end else begin
      m_tc = 1'b0;
      if (m_st == M_RUN) begin
        if (bus.pause) m_st = M_HOLD;
        else if (m_q == 0) m_q = m_rl;
        else begin
          m_q = m_q - 1;
          if (m_q == 0) begin
            m_tc = 1'b1;
            if (!bus.mode) m_st = M_DONE;
          end
        end
      end else if (m_st == M_HOLD) begin
        if (!bus.pause) m_st = M_RUN;
      end else if (m_st == M_DONE) begin
        m_q = 0;
      end
    end
  endtask

  function automatic logic [W+2:0] obs_vec();
    return {bus.q, bus.tc, bus.busy, bus.done};
  endfunction

  function automatic logic [W+2:0] exp_vec(int unsigned q, bit tc, bit busy, bit done);
    return {W'(q), tc, busy, done};
  endfunction

  task automatic idle_inputs();
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.load_val = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_load(int unsigned v);
    bus.load_val = W'(v);
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic do_start(bit m);
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+2:0] o;
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.start    = 1'b1;
    bus.load_val = W'($urandom);
    repeat (3) tick();
    idle_inputs();
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 0, 0, 0));
    end
    tick();
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_idle: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 0, 0, 0));
    end
  endtask

  task automatic test_one_shot();
    logic [W+2:0] o;
    logic [W+2:0] e;
    do_load(5);
    do_start(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      o = obs_vec();
      e = exp_vec(5 - i, i == 5, i != 5, i == 5);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL one_shot step %0d: got {q,tc,busy,done}=%b want %b", i, o, e);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      o = obs_vec();
      n_tests++;
      if (o !== exp_vec(0, 0, 0, 1)) begin
        n_fail++;
        $display("FAIL one_shot_hold %0d: got {q,tc,busy,done}=%b want %b", i, o, exp_vec(0, 0, 0, 1));
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [W+2:0] o;
    logic [W+2:0] e;
    do_load(3);
    do_start(1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      o = obs_vec();
      e = exp_vec(3 - (i % 4), (i % 4) == 3, 1, 0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL auto_reload step %0d: got {q,tc,busy,done}=%b want %b", i, o, e);
      end
    end
    bus.mode = 1'b0;
  endtask

  task automatic test_pause();
    logic [W+2:0] o;
    logic [W+2:0] e;
    do_load(9);
    do_start(1'b0);
    repeat (3) tick();
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      o = obs_vec();
      n_tests++;
      if (o !== exp_vec(6, 0, 1, 0)) begin
        n_fail++;
        $display("FAIL pause_hold %0d: got {q,tc,busy,done}=%b want %b", i, o, exp_vec(6, 0, 1, 0));
      end
    end
    bus.pause = 1'b0;
    tick();
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(6, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL pause_resume: got {q,tc,busy,done}=%b want %b", o, exp_vec(6, 0, 1, 0));
    end
    for (int v = 5; v >= 0; v--) begin
      tick();
      o = obs_vec();
      e = exp_vec(v, v == 0, v != 0, v == 0);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL pause_after q=%0d: got {q,tc,busy,done}=%b want %b", v, o, e);
      end
    end
  endtask

  task automatic test_priority();
    logic [W+2:0] o;
    logic [W+2:0] e;
    bus.load_val = W'(7);
    bus.load     = 1'b1;
    bus.start    = 1'b1;
    tick();
    idle_inputs();
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(7, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL load_over_start: got {q,tc,busy,done}=%b want %b", o, exp_vec(7, 0, 0, 0));
    end
    do_start(1'b0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(5, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL start_in_run: got {q,tc,busy,done}=%b want %b", o, exp_vec(5, 0, 1, 0));
    end
    do_load(0);
    do_start(1'b0);
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL zero_oneshot: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 1, 0, 1));
    end
    tick();
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 0, 0, 1)) begin
      n_fail++;
      $display("FAIL zero_oneshot_after: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 0, 0, 1));
    end
    do_load(0);
    do_start(1'b1);
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL zero_autoreload: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 1, 0, 0));
    end
    do_load(15);
    do_start(1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      o = obs_vec();
      e = exp_vec(15 - i, i == 15, i != 15, i == 15);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL full_range step %0d: got {q,tc,busy,done}=%b want %b", i, o, e);
      end
    end
    do_start(1'b0);
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(15, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL restart_from_done: got {q,tc,busy,done}=%b want %b", o, exp_vec(15, 0, 1, 0));
    end
  endtask

  task automatic test_load_abort();
    logic [W+2:0] o;
    do_load(12);
    do_start(1'b0);
    repeat (4) tick();
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(8, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL abort_setup: got {q,tc,busy,done}=%b want %b", o, exp_vec(8, 0, 1, 0));
    end
    do_load(2);
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(2, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL load_abort: got {q,tc,busy,done}=%b want %b", o, exp_vec(2, 0, 0, 0));
    end
  endtask

  task automatic test_reset_midcount();
    logic [W+2:0] o;
    do_load(9);
    do_start(1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_midcount: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 0, 0, 0));
    end
    // Reload register must have been cleared too, so start is a zero-interval count.
    do_start(1'b0);
    o = obs_vec();
    n_tests++;
    if (o !== exp_vec(0, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL reset_clears_reload: got {q,tc,busy,done}=%b want %b", o, exp_vec(0, 1, 0, 1));
    end
  endtask

  task automatic test_random();
    logic [W+2:0] o;
    logic [W+2:0] e;
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      bus.load     = ($urandom_range(0, 99) < 8);
      bus.start    = ($urandom_range(0, 99) < 15);
      bus.pause    = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 5) bus.mode = ~bus.mode;
      bus.load_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      tick();
      o = obs_vec();
      e = exp_vec(m_q, m_tc, (m_st == M_RUN) || (m_st == M_HOLD), m_st == M_DONE);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random cycle %0d: got {q,tc,busy,done}=%b want %b", i, o, e);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.mode = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_priority();
    test_load_abort();
    test_reset_midcount();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
